// File: rtl/pc_stack_ctrl.sv
// Saves/restores the 16-bit program counter on the 6502 hardware stack.
// Optional sticky stack-wrap flag OVF is built only when PC_STACK_OVF_EN is defined.
module pc_stack_ctrl #(
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter logic [7:0] SP_RESET   = 8'hFF
) (
    input  logic        CLK,
    input  logic        RN,
    input  logic        PUSH,
    input  logic        POP,
    input  logic [15:0] PC_IN,
    input  logic        SP_WR,
    input  logic [7:0]  SP_DI,
    input  logic        RDY,
    input  logic [7:0]  DI,
    output logic [15:0] ADDR,
    output logic [7:0]  DO,
    output logic        WE,
    output logic        RE,
    output logic [7:0]  LO,
    output logic [7:0]  HI,
    output logic        CI,
    output logic        WR,
    output logic [7:0]  SP,
    output logic        BUSY,
    output logic        OVF
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PSH_H = 3'd1;
    localparam logic [2:0] PSH_L = 3'd2;
    localparam logic [2:0] POP_L = 3'd3;
    localparam logic [2:0] POP_H = 3'd4;
    localparam logic [2:0] LOAD  = 3'd5;

    logic [2:0]  state;
    logic [7:0]  sp;
    logic [7:0]  sp_inc;
    logic [15:0] pc_lat;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
    logic        in_push;
    logic        in_pop;

    assign sp_inc  = sp + 8'd1;
    assign in_push = (state == PSH_H) || (state == PSH_L);
    assign in_pop  = (state == POP_L) || (state == POP_H);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            sp     <= SP_RESET;
            pc_lat <= 16'h0000;
            lo_q   <= 8'h00;
            hi_q   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (SP_WR) begin
                        sp <= SP_DI;
                    end else if (PUSH) begin
                        pc_lat <= PC_IN;
                        state  <= PSH_H;
                    end else if (POP) begin
                        state <= POP_L;
                    end
                end
                PSH_H: if (RDY) begin
                    sp    <= sp - 8'd1;
                    state <= PSH_L;
                end
                PSH_L: if (RDY) begin
                    sp    <= sp - 8'd1;
                    state <= IDLE;
                end
                POP_L: if (RDY) begin
                    lo_q  <= DI;
                    sp    <= sp_inc;
                    state <= POP_H;
                end
                POP_H: if (RDY) begin
                    hi_q  <= DI;
                    sp    <= sp_inc;
                    state <= LOAD;
                end
                LOAD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output is given a default before the case so no latch is inferred.
    always_comb begin
        ADDR = {STACK_PAGE, sp};
        DO   = 8'h00;
        WE   = 1'b0;
        RE   = 1'b0;
        case (state)
            PSH_H: begin
                WE = 1'b1;
                DO = pc_lat[15:8];
            end
            PSH_L: begin
                WE = 1'b1;
                DO = pc_lat[7:0];
            end
            POP_L, POP_H: begin
                RE   = 1'b1;
                ADDR = {STACK_PAGE, sp_inc};
            end
            default: ;
        endcase
    end

    assign WR   = (state == LOAD);
    assign BUSY = (state != IDLE);
    assign CI   = 1'b0;
    assign LO   = lo_q;
    assign HI   = hi_q;
    assign SP   = sp;

`ifdef PC_STACK_OVF_EN
    // Wrap is flagged only on accepted bus cycles that step SP across 00/FF.
    logic ovf_q;
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            ovf_q <= 1'b0;
        end else if (RDY && ((in_push && sp == 8'h00) || (in_pop && sp == 8'hFF))) begin
            ovf_q <= 1'b1;
        end
    end
    assign OVF = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = in_push ^ in_pop;
    assign OVF        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Self-checking bench for pc_stack_ctrl: directed spec scenarios plus randomized
// push/pop/SP-load traffic against a byte-array stack model with random RDY stalls.
module tb_pc_stack_ctrl;

    logic        clk;
    logic        rn;
    logic        push;
    logic        pop;
    logic [15:0] pc_in;
    logic        sp_wr;
    logic [7:0]  sp_di;
    logic        rdy;
    logic [7:0]  di;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        we;
    logic        re;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        ci;
    logic        wr;
    logic [7:0]  sp;
    logic        busy;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    // Bus-side memory (what the DUT really writes) and the reference model state.
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int         ref_sp;
    bit         ref_ovf;

`ifdef PC_STACK_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    pc_stack_ctrl dut (
        .CLK(clk), .RN(rn), .PUSH(push), .POP(pop), .PC_IN(pc_in),
        .SP_WR(sp_wr), .SP_DI(sp_di), .RDY(rdy), .DI(di),
        .ADDR(addr), .DO(data_out), .WE(we), .RE(re), .LO(lo), .HI(hi),
        .CI(ci), .WR(wr), .SP(sp), .BUSY(busy), .OVF(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we && rdy && addr[15:8] == 8'h01) mem[addr[7:0]] <= data_out;
    end
    always_comb di = re ? mem[addr[7:0]] : 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: stack of bytes in page 1, SP post-decrement / pre-increment.
    task automatic model_push(input logic [15:0] pc);
        ref_mem[ref_sp] = pc[15:8];
        if (ref_sp == 0) ref_ovf = OVF_EN;
        ref_sp = (ref_sp + 255) % 256;
        ref_mem[ref_sp] = pc[7:0];
        if (ref_sp == 0) ref_ovf = OVF_EN;
        ref_sp = (ref_sp + 255) % 256;
    endtask

    task automatic model_pop(output logic [7:0] elo, output logic [7:0] ehi);
        if (ref_sp == 255) ref_ovf = OVF_EN;
        ref_sp = (ref_sp + 1) % 256;
        elo = ref_mem[ref_sp];
        if (ref_sp == 255) ref_ovf = OVF_EN;
        ref_sp = (ref_sp + 1) % 256;
        ehi = ref_mem[ref_sp];
    endtask

    // Issues one request (0 push, 1 pop, 2 SP load) and runs it to completion,
    // recording what was observed on the DUT outputs.
    task automatic run_op(input int kind, input logic [15:0] pc, input logic [7:0] val,
                          input bit stall, output int cycles, output logic [7:0] lo_cap,
                          output logic [7:0] hi_cap, output int wr_cnt, output bit conflict,
                          output bit timeout);
        cycles = 0; wr_cnt = 0; conflict = 0; timeout = 0; lo_cap = 8'h00; hi_cap = 8'h00;
        rdy   = 1'b1;
        push  = (kind == 0);
        pop   = (kind == 1);
        sp_wr = (kind == 2);
        pc_in = pc;
        sp_di = val;
        tick();
        push = 1'b0; pop = 1'b0; sp_wr = 1'b0;
        pc_in = 16'($urandom);
        while (busy && cycles < 100) begin
            if ((we && re) || (wr && (we || re))) conflict = 1;
            if (wr) begin
                wr_cnt++;
                lo_cap = lo;
                hi_cap = hi;
            end
            cycles++;
            rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
        end
        if (busy) timeout = 1;
        rdy = 1'b1;
    endtask

    task automatic test_reset();
        rn = 1'b0; push = 0; pop = 0; sp_wr = 0; rdy = 1; pc_in = 0; sp_di = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sp, busy, we, re, wr, addr, ovf, lo, hi, ci} !==
            {8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h01FF, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: sp=%h busy=%b we=%b re=%b wr=%b addr=%h ovf=%b lo=%h hi=%h ci=%b required sp=ff addr=01ff others 0",
                     sp, busy, we, re, wr, addr, ovf, lo, hi, ci);
        end
        rn = 1'b1;
        ref_sp = 255; ref_ovf = 0;
        tick();
    endtask

    task automatic test_push_pop();
        logic [7:0] elo, ehi;
        // Push 1234 from SP=FF: two write cycles, high byte first.
        push = 1; pc_in = 16'h1234; tick(); push = 0;
        checks++;
        if ({we, re, addr, data_out, busy} !== {1'b1, 1'b0, 16'h01FF, 8'h12, 1'b1}) begin
            failures++;
            $display("FAIL push_hi_cycle: we=%b re=%b addr=%h do=%h busy=%b required we=1 addr=01ff do=12",
                     we, re, addr, data_out, busy);
        end
        tick();
        checks++;
        if ({we, re, addr, data_out} !== {1'b1, 1'b0, 16'h01FE, 8'h34}) begin
            failures++;
            $display("FAIL push_lo_cycle: we=%b addr=%h do=%h required we=1 addr=01fe do=34", we, addr, data_out);
        end
        tick();
        model_push(16'h1234);
        checks++;
        if ({sp, busy, we} !== {8'hFD, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL push_done: sp=%h busy=%b we=%b required sp=fd busy=0 we=0", sp, busy, we);
        end
        // Pop it back: read 01FE then 01FF, then a single load cycle.
        pop = 1; tick(); pop = 0;
        checks++;
        if ({re, we, addr, di} !== {1'b1, 1'b0, 16'h01FE, 8'h34}) begin
            failures++;
            $display("FAIL pop_lo_cycle: re=%b we=%b addr=%h di=%h required re=1 addr=01fe di=34", re, we, addr, di);
        end
        tick();
        checks++;
        if ({re, addr, di} !== {1'b1, 16'h01FF, 8'h12}) begin
            failures++;
            $display("FAIL pop_hi_cycle: re=%b addr=%h di=%h required re=1 addr=01ff di=12", re, addr, di);
        end
        tick();
        model_pop(elo, ehi);
        checks++;
        if ({wr, lo, hi, ci, we, re, sp, busy} !== {1'b1, elo, ehi, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL pop_load_cycle: wr=%b lo=%h hi=%h ci=%b we=%b re=%b sp=%h required wr=1 lo=%h hi=%h sp=ff",
                     wr, lo, hi, ci, we, re, sp, elo, ehi);
        end
        tick();
        checks++;
        if ({wr, busy, lo, hi} !== {1'b0, 1'b0, 8'h34, 8'h12}) begin
            failures++;
            $display("FAIL pop_after_load: wr=%b busy=%b lo=%h hi=%h required wr=0 busy=0 lo=34 hi=12", wr, busy, lo, hi);
        end
    endtask

    task automatic test_stall();
        int n;
        bit held_ok;
        push = 1; pc_in = 16'h1234; tick(); push = 0;
        n = 1;
        tick(); n++;
        rdy = 0;
        held_ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); n++;
            if ({we, addr, data_out, sp} !== {1'b1, 16'h01FE, 8'h34, 8'hFE}) held_ok = 0;
        end
        rdy = 1;
        while (busy && n < 20) begin tick(); n++; end
        model_push(16'h1234);
        checks++;
        if (!held_ok) begin
            failures++;
            $display("FAIL stall_hold: we=%b addr=%h do=%h sp=%h required we=1 addr=01fe do=34 sp=fe while stalled",
                     we, addr, data_out, sp);
        end
        checks++;
        if (n - 1 !== 5 || sp !== ref_sp[7:0]) begin
            failures++;
            $display("FAIL stall_total: busy_cycles=%0d sp=%h required 5 cycles sp=%h", n - 1, sp, ref_sp[7:0]);
        end
    endtask

    task automatic test_wrap();
        int cyc, wc;
        logic [7:0] l, h;
        bit cf, to;
        run_op(2, 16'h0000, 8'h00, 0, cyc, l, h, wc, cf, to);
        ref_sp = 0;
        checks++;
        if (sp !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_sp_load: sp=%h busy=%b required sp=00 busy=0", sp, busy);
        end
        run_op(0, 16'hABCD, 8'h00, 0, cyc, l, h, wc, cf, to);
        model_push(16'hABCD);
        checks++;
        if ({mem[8'h00], mem[8'hFF], sp, ovf} !== {8'hAB, 8'hCD, 8'hFE, ref_ovf}) begin
            failures++;
            $display("FAIL wrap_push: m0100=%h m01ff=%h sp=%h ovf=%b required ab cd fe ovf=%b",
                     mem[8'h00], mem[8'hFF], sp, ovf, ref_ovf);
        end
    endtask

    task automatic test_priority();
        logic [7:0] sp0;
        int n;
        sp0 = sp;
        // PUSH and POP together: push wins; POP raised while busy is ignored.
        push = 1; pop = 1; pc_in = 16'h5A5A; tick(); push = 0;
        checks++;
        if ({we, re, data_out} !== {1'b1, 1'b0, 8'h5A}) begin
            failures++;
            $display("FAIL push_over_pop: we=%b re=%b do=%h required we=1 re=0 do=5a", we, re, data_out);
        end
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        pop = 0;
        model_push(16'h5A5A);
        tick();
        checks++;
        if ({busy, re, sp} !== {1'b0, 1'b0, ref_sp[7:0]}) begin
            failures++;
            $display("FAIL pop_ignored_busy: busy=%b re=%b sp=%h required busy=0 re=0 sp=%h", busy, re, sp, ref_sp[7:0]);
        end
        // SP_WR and PUSH together: SP loaded, no push started.
        sp_wr = 1; push = 1; sp_di = 8'h80; pc_in = 16'hFFFF; tick(); sp_wr = 0; push = 0;
        ref_sp = 8'h80;
        checks++;
        if ({sp, busy, we} !== {8'h80, 1'b0, 1'b0} || sp0 === 8'h80) begin
            failures++;
            $display("FAIL spwr_over_push: sp=%h busy=%b we=%b required sp=80 busy=0 we=0", sp, busy, we);
        end
    endtask

    task automatic test_abort();
        push = 1; pc_in = 16'hBEEF; tick(); push = 0;
        tick();
        rn = 0;
        #1;
        checks++;
        if ({busy, we, re, wr, sp, addr, ovf} !== {1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h01FF, 1'b0}) begin
            failures++;
            $display("FAIL reset_abort: busy=%b we=%b re=%b wr=%b sp=%h addr=%h ovf=%b required idle sp=ff addr=01ff",
                     busy, we, re, wr, sp, addr, ovf);
        end
        @(negedge clk);
        rn = 1;
        ref_sp = 255; ref_ovf = 0;
        tick();
    endtask

    task automatic test_random();
        int cyc, wc, kind;
        logic [7:0] l, h, elo, ehi, v;
        logic [15:0] pc;
        bit cf, to, stall;
        for (int i = 0; i < 60; i++) begin
            kind  = $urandom_range(0, 9) < 4 ? 0 : ($urandom_range(0, 9) < 7 ? 1 : 2);
            pc    = 16'($urandom);
            v     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(253, 255));
            stall = $urandom_range(0, 1) == 1;
            run_op(kind, pc, v, stall, cyc, l, h, wc, cf, to);
            if (kind == 0) model_push(pc);
            else if (kind == 1) model_pop(elo, ehi);
            else ref_sp = v;
            checks++;
            if (to || cf || sp !== ref_sp[7:0] || ovf !== ref_ovf) begin
                failures++;
                $display("FAIL rand_op%0d kind=%0d: timeout=%b conflict=%b sp=%h ovf=%b required sp=%h ovf=%b",
                         i, kind, to, cf, sp, ovf, ref_sp[7:0], ref_ovf);
            end
            if (kind == 1) begin
                checks++;
                if (wc !== 1 || l !== elo || h !== ehi) begin
                    failures++;
                    $display("FAIL rand_pop%0d: wr_cycles=%0d lo=%h hi=%h required 1 lo=%h hi=%h", i, wc, l, h, elo, ehi);
                end
            end
            if (!stall && kind != 2) begin
                checks++;
                if (cyc !== (kind == 0 ? 2 : 3)) begin
                    failures++;
                    $display("FAIL rand_len%0d: cycles=%0d required %0d", i, cyc, kind == 0 ? 2 : 3);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_push_pop();
        test_stall();
        test_wrap();
        test_priority();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
